// File: rtl/control_unit_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, FSM states, datapath select codes
// and the one-hot instruction class produced by the decoder.
package control_unit_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDA   = 4'h1;
    localparam logic [3:0] OP_STA   = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_LDI   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_JP    = 4'h8;
    localparam logic [3:0] OP_IN    = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;
    localparam logic [3:0] OP_SHF   = 4'hB;
    localparam logic [3:0] OP_ADD   = 4'hC;
    localparam logic [3:0] OP_SUB   = 4'hD;
    localparam logic [3:0] OP_LOGIC = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_OPERAND = 3'd2,
        S_MEMACC  = 3'd3,
        S_INWAIT  = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    localparam logic [2:0] ASEL_SHFT = 3'b000;
    localparam logic [2:0] ASEL_RF   = 3'b001;
    localparam logic [2:0] ASEL_IN   = 3'b010;
    localparam logic [2:0] ASEL_MEM  = 3'b011;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_SHL  = 2'b01;
    localparam logic [1:0] SH_SHR  = 2'b10;
    localparam logic [1:0] SH_ROTR = 2'b11;

    localparam logic [1:0] JMP_INC  = 2'b00;
    localparam logic [1:0] JMP_ABS  = 2'b01;
    localparam logic [1:0] JMP_BACK = 2'b10;
    localparam logic [1:0] JMP_FWD  = 2'b11;

    // Field order follows opcode order: opcode 0 is the MSB, opcode 15 the LSB.
    typedef struct packed {
        logic nop;
        logic lda;
        logic sta;
        logic load;
        logic store;
        logic ldi;
        logic jmp;
        logic jz;
        logic jp;
        logic in_op;
        logic out_op;
        logic shf;
        logic add;
        logic sub;
        logic lgc;
        logic hlt;
    } iclass_t;

endpackage

// File: rtl/control_unit_inst_decode.sv
// Opcode to one-hot instruction class, plus a flag for instructions that carry an operand byte.
module inst_decode
    import control_unit_pkg::*;
(
    input  logic [3:0] op,
    output iclass_t    ic,
    output logic       two_byte
);

    // Struct layout mirrors opcode numbering, so a shifted MSB is the one-hot class.
    assign ic       = iclass_t'(16'h8000 >> op);
    assign two_byte = ic.load | ic.store | ic.ldi | ic.jmp;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit accumulator CPU; all datapath strobes and selects
// are combinational from the state, IR and the status flags.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] IR,
    input  logic              Aeq0,
    input  logic              apos,
    input  logic              enter,
    output logic              IRload,
    output logic              PCload,
    output logic              MemInst,
    output logic              MRload,
    output logic              memWr,
    output logic              Aload,
    output logic              RFwr,
    output logic              outen,
    output logic [1:0]        JMPmux,
    output logic [2:0]        Asel,
    output logic [2:0]        ALUsel,
    output logic [1:0]        Shftsel,
    output logic              inwait,
    output logic              halted
);

    if (DATA_W != 8 || ADDR_W != 6) begin : g_bad_param
        $error("control_unit supports only DATA_W=8, ADDR_W=6");
    end

    state_e  state_q, state_d;
    iclass_t ic;
    logic    two_byte;
    logic    unused_ir;

    assign unused_ir = IR[2];

    inst_decode u_dec (
        .op       (IR[7:4]),
        .ic       (ic),
        .two_byte (two_byte)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        IRload  = 1'b0;
        PCload  = 1'b0;
        MemInst = 1'b0;
        MRload  = 1'b0;
        memWr   = 1'b0;
        Aload   = 1'b0;
        RFwr    = 1'b0;
        outen   = 1'b0;
        JMPmux  = JMP_INC;
        Asel    = ASEL_SHFT;
        ALUsel  = ALU_PASS;
        Shftsel = SH_NONE;
        inwait  = 1'b0;
        halted  = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRload  = 1'b1;
                PCload  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = two_byte ? S_OPERAND : S_FETCH;
                if (ic.lda) begin
                    Asel  = ASEL_RF;
                    Aload = 1'b1;
                end
                if (ic.sta)    RFwr  = 1'b1;
                if (ic.out_op) outen = 1'b1;
                // IR[3] set means the offset is subtracted from the already-incremented PC.
                if ((ic.jz && Aeq0) || (ic.jp && apos)) begin
                    PCload = 1'b1;
                    JMPmux = IR[3] ? JMP_BACK : JMP_FWD;
                end
                if (ic.shf || ic.add || ic.sub || ic.lgc) begin
                    Asel  = ASEL_SHFT;
                    Aload = 1'b1;
                end
                if (ic.shf) Shftsel = IR[1:0];
                if (ic.add) ALUsel  = ALU_ADD;
                if (ic.sub) ALUsel  = ALU_SUB;
                if (ic.lgc) ALUsel  = IR[3] ? ALU_OR : ALU_AND;
                if (ic.in_op) state_d = S_INWAIT;
                if (ic.hlt)   state_d = S_HALT;
            end
            S_OPERAND: begin
                state_d = S_FETCH;
                if (ic.load || ic.store) begin
                    MRload  = 1'b1;
                    PCload  = 1'b1;
                    state_d = S_MEMACC;
                end
                if (ic.ldi) begin
                    Asel   = ASEL_MEM;
                    Aload  = 1'b1;
                    PCload = 1'b1;
                end
                if (ic.jmp) begin
                    PCload = 1'b1;
                    JMPmux = JMP_ABS;
                end
            end
            S_MEMACC: begin
                MemInst = 1'b1;
                state_d = S_FETCH;
                if (ic.load) begin
                    Asel  = ASEL_MEM;
                    Aload = 1'b1;
                end
                if (ic.store) memWr = 1'b1;
            end
            S_INWAIT: begin
                inwait = 1'b1;
                if (enter) begin
                    Asel    = ASEL_IN;
                    Aload   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Outputs are forced low combinationally so a reset mid-STORE never reaches a memWr edge.
        if (!reset) begin
            IRload  = 1'b0;
            PCload  = 1'b0;
            MemInst = 1'b0;
            MRload  = 1'b0;
            memWr   = 1'b0;
            Aload   = 1'b0;
            RFwr    = 1'b0;
            outen   = 1'b0;
            JMPmux  = JMP_INC;
            Asel    = ASEL_SHFT;
            ALUsel  = ALU_PASS;
            Shftsel = SH_NONE;
            inwait  = 1'b0;
            halted  = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each step drives IR/flags/enter after a falling edge
// and compares the packed control word against a hand-computed value.
module tb_control_unit;
    import control_unit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IR;
    logic       Aeq0, apos, enter;
    logic       IRload, PCload, MemInst, MRload, memWr, Aload, RFwr, outen;
    logic [1:0] JMPmux, Shftsel;
    logic [2:0] Asel, ALUsel;
    logic       inwait, halted;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] S_IRL = 8'h80;
    localparam logic [7:0] S_PCL = 8'h40;
    localparam logic [7:0] S_MI  = 8'h20;
    localparam logic [7:0] S_MR  = 8'h10;
    localparam logic [7:0] S_MW  = 8'h08;
    localparam logic [7:0] S_AL  = 8'h04;
    localparam logic [7:0] S_RF  = 8'h02;
    localparam logic [7:0] S_OE  = 8'h01;

    control_unit #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .IR(IR), .Aeq0(Aeq0), .apos(apos), .enter(enter),
        .IRload(IRload), .PCload(PCload), .MemInst(MemInst), .MRload(MRload),
        .memWr(memWr), .Aload(Aload), .RFwr(RFwr), .outen(outen),
        .JMPmux(JMPmux), .Asel(Asel), .ALUsel(ALUsel), .Shftsel(Shftsel),
        .inwait(inwait), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {IRload, PCload, MemInst, MRload, memWr, Aload, RFwr, outen,
                  JMPmux, Asel, ALUsel, Shftsel, inwait, halted};

    function automatic logic [19:0] e(input logic [7:0] strb, input logic [1:0] jm,
                                      input logic [2:0] as, input logic [2:0] alu,
                                      input logic [1:0] sh, input logic iw, input logic h);
        return {strb, jm, as, alu, sh, iw, h};
    endfunction

    localparam logic [19:0] ZERO  = 20'h0;
    localparam logic [19:0] FETCH = {S_IRL | S_PCL, 12'h0};

    task automatic cyc(input string tag, input logic rs, input logic [7:0] ir,
                       input logic z, input logic p, input logic en, input logic [19:0] exp);
        @(negedge clk);
        reset = rs;
        IR    = ir;
        Aeq0  = z;
        apos  = p;
        enter = en;
        #1;
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; IR = 8'h00; Aeq0 = 1'b0; apos = 1'b0; enter = 1'b0;

        // Reset held for three cycles with assorted inputs
        cyc("rst_a", 0, 8'h50, 1, 1, 1, ZERO);
        cyc("rst_b", 0, 8'hF0, 0, 1, 1, ZERO);
        cyc("rst_c", 0, 8'h90, 1, 0, 0, ZERO);
        cyc("fetch_first", 1, 8'h50, 0, 0, 0, FETCH);

        // LDI then ADD
        cyc("ldi_dec",  1, 8'h50, 0, 0, 0, ZERO);
        cyc("ldi_opnd", 1, 8'h50, 0, 0, 0, e(S_AL | S_PCL, JMP_INC, ASEL_MEM, ALU_PASS, SH_NONE, 0, 0));
        cyc("add_fetch", 1, 8'hC1, 0, 0, 0, FETCH);
        cyc("add_dec",  1, 8'hC1, 0, 0, 0, e(S_AL, JMP_INC, ASEL_SHFT, ALU_ADD, SH_NONE, 0, 0));

        // STORE: 4 cycles, memWr only in MEMACC
        cyc("st_fetch", 1, 8'h40, 0, 0, 0, FETCH);
        cyc("st_dec",   1, 8'h40, 0, 0, 0, ZERO);
        cyc("st_opnd",  1, 8'h40, 0, 0, 0, e(S_MR | S_PCL, JMP_INC, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));
        cyc("st_mem",   1, 8'h40, 0, 0, 0, e(S_MI | S_MW, JMP_INC, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));

        // Conditional branches
        cyc("jz_fetch",    1, 8'h7B, 1, 0, 0, FETCH);
        cyc("jz_back_tk",  1, 8'h7B, 1, 0, 0, e(S_PCL, JMP_BACK, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));
        cyc("jz_fetch2",   1, 8'h7B, 0, 1, 0, FETCH);
        cyc("jz_not_tk",   1, 8'h7B, 0, 1, 0, ZERO);
        cyc("jz_fetch3",   1, 8'h73, 1, 0, 0, FETCH);
        cyc("jz_fwd_tk",   1, 8'h73, 1, 0, 0, e(S_PCL, JMP_FWD, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));
        cyc("jp_fetch",    1, 8'h80, 0, 1, 0, FETCH);
        cyc("jp_fwd_tk",   1, 8'h80, 0, 1, 0, e(S_PCL, JMP_FWD, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));
        cyc("jp_fetch2",   1, 8'h88, 1, 0, 0, FETCH);
        cyc("jp_not_tk",   1, 8'h88, 1, 0, 0, ZERO);

        // IN: enter already high in DECODE is ignored, then 5 idle wait cycles
        cyc("in_fetch", 1, 8'h90, 0, 0, 1, FETCH);
        cyc("in_dec",   1, 8'h90, 0, 0, 1, ZERO);
        for (int i = 0; i < 5; i++)
            cyc("in_wait", 1, 8'h90, 0, 0, 0, e(8'h00, JMP_INC, ASEL_SHFT, ALU_PASS, SH_NONE, 1, 0));
        cyc("in_take",  1, 8'h90, 0, 0, 1, e(S_AL, JMP_INC, ASEL_IN, ALU_PASS, SH_NONE, 1, 0));
        cyc("in_after", 1, 8'h30, 0, 0, 1, FETCH);

        // LOAD
        cyc("ld_dec",  1, 8'h30, 0, 0, 1, ZERO);
        cyc("ld_opnd", 1, 8'h30, 0, 0, 0, e(S_MR | S_PCL, JMP_INC, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));
        cyc("ld_mem",  1, 8'h30, 0, 0, 0, e(S_MI | S_AL, JMP_INC, ASEL_MEM, ALU_PASS, SH_NONE, 0, 0));

        // Remaining one-byte ops, each FETCH + DECODE
        cyc("sta_f", 1, 8'h22, 0, 0, 0, FETCH);
        cyc("sta_d", 1, 8'h22, 0, 0, 0, e(S_RF, JMP_INC, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));
        cyc("lda_f", 1, 8'h11, 0, 0, 0, FETCH);
        cyc("lda_d", 1, 8'h11, 0, 0, 0, e(S_AL, JMP_INC, ASEL_RF, ALU_PASS, SH_NONE, 0, 0));
        cyc("out_f", 1, 8'hA0, 0, 0, 0, FETCH);
        cyc("out_d", 1, 8'hA0, 0, 0, 0, e(S_OE, JMP_INC, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));
        cyc("shf_f", 1, 8'hB2, 0, 0, 0, FETCH);
        cyc("shf_d", 1, 8'hB2, 0, 0, 0, e(S_AL, JMP_INC, ASEL_SHFT, ALU_PASS, SH_SHR, 0, 0));
        cyc("sub_f", 1, 8'hD3, 0, 0, 0, FETCH);
        cyc("sub_d", 1, 8'hD3, 0, 0, 0, e(S_AL, JMP_INC, ASEL_SHFT, ALU_SUB, SH_NONE, 0, 0));
        cyc("or_f",  1, 8'hE8, 0, 0, 0, FETCH);
        cyc("or_d",  1, 8'hE8, 0, 0, 0, e(S_AL, JMP_INC, ASEL_SHFT, ALU_OR, SH_NONE, 0, 0));
        cyc("and_f", 1, 8'hE1, 0, 0, 0, FETCH);
        cyc("and_d", 1, 8'hE1, 0, 0, 0, e(S_AL, JMP_INC, ASEL_SHFT, ALU_AND, SH_NONE, 0, 0));
        cyc("nop_f", 1, 8'h0F, 1, 1, 1, FETCH);
        cyc("nop_d", 1, 8'h0F, 1, 1, 1, ZERO);

        // JMP
        cyc("jmp_f", 1, 8'h60, 0, 0, 0, FETCH);
        cyc("jmp_d", 1, 8'h60, 0, 0, 0, ZERO);
        cyc("jmp_o", 1, 8'h60, 0, 0, 0, e(S_PCL, JMP_ABS, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));

        // Reset asserted in the MEMACC cycle of a STORE
        cyc("rst_st_f", 1, 8'h40, 0, 0, 0, FETCH);
        cyc("rst_st_d", 1, 8'h40, 0, 0, 0, ZERO);
        cyc("rst_st_o", 1, 8'h40, 0, 0, 0, e(S_MR | S_PCL, JMP_INC, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 0));
        cyc("rst_st_m", 0, 8'h40, 0, 0, 0, ZERO);
        cyc("rst_st_h", 0, 8'h40, 0, 0, 0, ZERO);
        cyc("rst_st_r", 1, 8'hF0, 0, 0, 0, FETCH);

        // HALT: only reset leaves
        cyc("hlt_d", 1, 8'hF0, 0, 0, 0, ZERO);
        for (int i = 0; i < 10; i++)
            cyc("hlt_hold", 1, 8'hF0, i[0], 1, (i == 2), e(8'h00, JMP_INC, ASEL_SHFT, ALU_PASS, SH_NONE, 0, 1));
        cyc("hlt_rst", 0, 8'hF0, 0, 0, 0, ZERO);
        cyc("hlt_rel", 1, 8'h00, 0, 0, 0, FETCH);
        cyc("hlt_dec", 1, 8'h00, 0, 0, 0, ZERO);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM sequencer for the 8-bit accumulator CPU datapath.
- Drives every datapath load, select and write strobe from the current state, the instruction register value and the status flags Aeq0 and apos.
- Fetches 1- and 2-byte instructions, runs ALU, shift, register-file, memory, branch and I/O operations, and stalls on external input.
- Sits beside the datapath in the CPU top level; its outputs connect 1:1 to the datapath control inputs of the same name.

Parameters:
- DATA_W, 8, instruction and data width. Only 8 is supported.
- ADDR_W, 6, PC and RAM address width. Only 6 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IR  in  8  instruction register contents. Opcode is IR[7:4], IR[3] is the modifier, IR[2:0] is the register or offset.
- Aeq0  in  1  accumulator is zero.
- apos  in  1  accumulator bit 7 is clear.
- enter  in  1  external input valid (level).
- IRload, PCload, MemInst, MRload, memWr, Aload, RFwr, outen  out  1 each  datapath strobes.
- JMPmux  out  2  PC source: 00 PC+1, 01 memout[5:0], 10 PC-off, 11 PC+off.
- Asel  out  3  acc source: 000 shifter, 001 regfile, 010 inext, 011 memout.
- ALUsel  out  3  000 passA, 001 AND, 010 OR, 011 ADD, 100 SUB.
- Shftsel  out  2  00 none, 01 shl, 10 shr, 11 rotr.
- inwait  out  1  high while stalled for enter.
- halted  out  1  high in HALT.

Behaviour:
- RAM timing: reads are combinational from the RAM address; writes occur on the clk edge. Every strobe is a single-cycle pulse.
- Outputs are combinational from state, IR and flags. While reset=0: state is FETCH and every output is 0.
- A strobe that is not listed for a state is 0. Select lines that are not listed are 0.
- States are FETCH, DECODE, OPERAND, MEMACC, INWAIT, HALT.
- FETCH: MemInst=0, IRload=1, PCload=1, JMPmux=00. Next state is DECODE.
- DECODE executes one-byte opcodes, then goes to FETCH unless noted:
  - 0000 NOP: no strobes.
  - 0001 LDA: Asel=001, Aload=1.
  - 0010 STA: RFwr=1.
  - 0111 JZ: if Aeq0, PCload=1 and JMPmux = IR[3] ? 10 : 11.
  - 1000 JP: same as JZ, conditioned on apos.
  - 1001 IN: next state is INWAIT. Issues no strobe in DECODE, even if enter is already high.
  - 1010 OUT: outen=1.
  - 1011 SHF: ALUsel=000, Shftsel=IR[1:0], Asel=000, Aload=1.
  - 1100 ADD: ALUsel=011, Shftsel=00, Asel=000, Aload=1.
  - 1101 SUB: ALUsel=100, otherwise as ADD.
  - 1110 logic: ALUsel = IR[3] ? 010 : 001, otherwise as ADD.
  - 1111 HALT: next state is HALT.
  - 0011, 0100, 0101, 0110: next state is OPERAND.
- Relative branch offsets apply to the PC after fetch, i.e. the address of the next instruction.
- OPERAND: MemInst=0, with the PC pointing at the operand byte.
  - 0011 LOAD and 0100 STORE: MRload=1, PCload=1, JMPmux=00. Next state is MEMACC.
  - 0101 LDI: Asel=011, Aload=1, PCload=1, JMPmux=00. Next state is FETCH.
  - 0110 JMP: PCload=1, JMPmux=01. Next state is FETCH.
- MEMACC: MemInst=1.
  - LOAD: Asel=011, Aload=1.
  - STORE: memWr=1.
  - Next state is FETCH.
- INWAIT: inwait=1.
  - If enter=1: Asel=010, Aload=1, next state is FETCH.
  - Otherwise hold in INWAIT.
  - IN therefore takes at least 3 cycles, and an enter held high is consumed once per IN.
- HALT: halted=1. No strobes. Only reset leaves this state.
- Cycle counts: one-byte ops take 2 cycles, LDI and JMP take 3, LOAD and STORE take 4.
- Reset asserted in any state, including mid-STORE: outputs go to 0 immediately and no memWr edge is produced. On release, execution starts in FETCH.
- Flags are sampled in the DECODE cycle only.

Decomposition:
- cpu_defs.vh holds the opcode localparams, state encoding, and the Asel, ALUsel, Shftsel and JMPmux codes. It is shared with the datapath and the bench.
- One sub-module, inst_decode: combinational, IR[7:4] to one-hot instruction class plus a 2-byte flag.

Test Plan:
- Hold reset low for 3 cycles, then release -> all outputs 0 during reset; first cycle shows IRload=1, PCload=1, JMPmux=00.
- LDI 0x5A, then ADD R1 with R1=0x05 -> A=0x5F after 5 cycles; Aload pulses once in OPERAND and once in DECODE.
- STORE to address 0x2A with A=0x33 -> MEMACC shows MemInst=1 and memWr=1 for exactly one cycle; RAM[0x2A]=0x33; total 4 cycles.
- JZ, IR=0x7B (back 3) at PC=0x10 with A=0 -> PC=0x0E; same instruction with A=1 -> PC=0x11, no PCload in DECODE.
- IN with enter low for 5 cycles, then high with inext=0xC3 -> inwait high for 6 cycles, A=0xC3, single Aload.
- HALT, then pulse enter and hold 10 cycles -> halted=1 and no strobes; reset low returns to FETCH.
